// File: rtl/ln_stat_engine.sv
// ln_stat_engine: streaming LayerNorm statistics (per-pixel mean and variance).
//
// Channel-slice vectors arrive surface-major: slice 0 for every pixel, then
// slice 1 for every pixel, and so on. Per-pixel partial {sum, sum of squares}
// live in an internal RAM. After the last slice the engine streams out
// mean/variance per pixel, in pixel order.
//
// Optional feature macro: LN_STAT_RMS_EN adds cfg_rms. With cfg_rms=1 the
// mean output is forced to 0 and out_var carries the mean square (RMSNorm).
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               one-cycle pulse, samples cfg_*
//   cfg_pixel_num       pixel count, 1..2^LOG2_PIXEL
//   cfg_ch_slice        slices per pixel, 1..MAX_CH_SLICE
//   cfg_recip_ch        unsigned Q0.16 round(65536/channel_count)
//   cfg_rms             (LN_STAT_RMS_EN only) RMSNorm mode
//   in_valid/in_ready   input vector handshake, in_data lanes signed
//   out_valid/out_ready statistics handshake
//   out_pixel           pixel index of the current output
//   out_mean            signed mean, 8 fractional bits
//   out_var             unsigned variance, 8 fractional bits
//   busy                high outside IDLE
//   done                one-cycle pulse after the last output handshake
//   cfg_err             one-cycle pulse on start with an illegal configuration
//
// state | meaning
// IDLE  | waiting for start
// ACCUM | accepting slices, accumulating into the pixel RAM
// DRAIN | lets the final accumulation write land
// EMIT  | read / multiply / subtract pipeline streaming statistics out
module ln_stat_engine #(
  parameter int TOUT         = 32,
  parameter int DAT_DW       = 8,
  parameter int LOG2_PIXEL   = 9,
  parameter int MAX_CH_SLICE = 64,
  parameter int SUM_DW       = DAT_DW + $clog2(TOUT*MAX_CH_SLICE),
  parameter int SQ_DW        = 2*DAT_DW + $clog2(TOUT*MAX_CH_SLICE)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [LOG2_PIXEL:0]           cfg_pixel_num,
  input  logic [$clog2(MAX_CH_SLICE):0] cfg_ch_slice,
  input  logic [15:0]                   cfg_recip_ch,
`ifdef LN_STAT_RMS_EN
  input  logic                          cfg_rms,
`endif
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [TOUT*DAT_DW-1:0]        in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LOG2_PIXEL-1:0]         out_pixel,
  output logic signed [DAT_DW+7:0]      out_mean,
  output logic [2*DAT_DW+7:0]           out_var,
  output logic                          busy,
  output logic                          done,
  output logic                          cfg_err
);

  localparam int PIX_W  = LOG2_PIXEL + 1;
  localparam int CS_W   = $clog2(MAX_CH_SLICE) + 1;
  localparam int DEPTH  = 1 << LOG2_PIXEL;
  localparam int RAM_W  = SUM_DW + SQ_DW;
  localparam int MEAN_W = DAT_DW + 8;
  localparam int VAR_W  = 2*DAT_DW + 8;
  localparam int PM_W   = SUM_DW + 17;
  localparam int PS_W   = SQ_DW + 16;
  localparam int MSQ_W  = 2*MEAN_W;
  localparam int DIFF_W = PS_W + 1;
  localparam int LVLS   = $clog2(TOUT);
  localparam int NP     = 1 << LVLS;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, EMIT} state_t;
  state_t state, state_nxt;

  // configuration latched on start
  logic [PIX_W-1:0] pix_num_q;
  logic [CS_W-1:0]  ch_slice_q;
  logic [15:0]      recip_q;
  logic             rms_q;

  logic [LOG2_PIXEL-1:0] pix_cnt;
  logic [CS_W-1:0]       slice_cnt;

  logic cfg_ok, hs, pix_last, last_beat, adv, issue_ok, out_fire, last_out;

  assign cfg_ok = (cfg_pixel_num != '0) && (cfg_pixel_num <= PIX_W'(DEPTH)) &&
                  (cfg_ch_slice != '0) && (cfg_ch_slice <= CS_W'(MAX_CH_SLICE));
  assign hs        = in_valid && (state == ACCUM);
  assign pix_last  = ({1'b0, pix_cnt} == pix_num_q - PIX_W'(1));
  assign last_beat = pix_last && (slice_cnt == ch_slice_q - CS_W'(1));
  assign adv       = (state == EMIT) && (!out_valid || out_ready);
  assign out_fire  = (state == EMIT) && out_valid && out_ready;
  assign last_out  = ({1'b0, out_pixel} == pix_num_q - PIX_W'(1));

  // lane sum / sum-of-squares adder tree (heap indexed, leaves at NP-1..2NP-2)
  logic signed [SUM_DW-1:0] sum_tree [0:2*NP-2];
  logic        [SQ_DW-1:0]  sq_tree  [0:2*NP-2];

  for (genvar i = 0; i < NP; i++) begin : g_leaf
    if (i < TOUT) begin : g_lane
      logic signed [DAT_DW-1:0]   lane;
      logic signed [2*DAT_DW-1:0] lane_sq;
      assign lane    = in_data[i*DAT_DW +: DAT_DW];
      assign lane_sq = (2*DAT_DW)'(lane) * (2*DAT_DW)'(lane);
      assign sum_tree[NP-1+i] = SUM_DW'(lane);
      assign sq_tree[NP-1+i]  = SQ_DW'($unsigned(lane_sq));
    end else begin : g_pad
      assign sum_tree[NP-1+i] = '0;
      assign sq_tree[NP-1+i]  = '0;
    end
  end
  for (genvar i = 0; i < NP-1; i++) begin : g_node
    assign sum_tree[i] = sum_tree[2*i+1] + sum_tree[2*i+2];
    assign sq_tree[i]  = sq_tree[2*i+1] + sq_tree[2*i+2];
  end

  // pixel RAM: one read port shared by ACCUM and EMIT, one write port
  logic [RAM_W-1:0] mem [0:DEPTH-1];
  logic [RAM_W-1:0] rd_raw, byp_data, old_word, wr_data;
  logic             rd_en, wr_en, byp_sel;
  logic [LOG2_PIXEL-1:0] rd_addr;

  logic                     s1_valid, s1_first;
  logic [LOG2_PIXEL-1:0]    s1_addr;
  logic signed [SUM_DW-1:0] s1_sum, old_sum;
  logic [SQ_DW-1:0]         s1_sq, old_sq;

  logic [PIX_W-1:0] iss_cnt;

  assign issue_ok = (iss_cnt < pix_num_q);
  assign rd_en    = hs || (adv && issue_ok);
  assign rd_addr  = (state == ACCUM) ? pix_cnt : iss_cnt[LOG2_PIXEL-1:0];
  assign wr_en    = s1_valid;

  // a write landing on the address being read returns stale RAM data, so the
  // written word is forwarded instead
  assign old_word = byp_sel ? byp_data : rd_raw;
  assign old_sum  = old_word[RAM_W-1:SQ_DW];
  assign old_sq   = old_word[SQ_DW-1:0];
  assign wr_data  = s1_first ? {s1_sum, s1_sq} : {s1_sum + old_sum, s1_sq + old_sq};

  always_ff @(posedge clk) begin
    if (wr_en) mem[s1_addr] <= wr_data;
    if (rd_en) rd_raw <= mem[rd_addr];
  end

  // emit pipeline: stage a = RAM read, stage b = multiply, out = subtract/clamp
  logic                     a_valid, b_valid;
  logic [LOG2_PIXEL-1:0]    a_pix, b_pix;
  logic signed [PM_W-1:0]   b_pm, mean_full;
  logic [PS_W-1:0]          b_ps, sq_sh;
  logic signed [MEAN_W-1:0] mean_c, mean_o;
  logic signed [MSQ_W-1:0]  msq;
  logic signed [DIFF_W-1:0] var_diff;
  logic [VAR_W-1:0]         var_c, var_o;
  logic                     unused_hi;

  assign mean_full = b_pm >>> 8;
  assign mean_c    = mean_full[MEAN_W-1:0];
  assign msq       = MSQ_W'(mean_c) * MSQ_W'(mean_c);
  assign sq_sh     = b_ps >> 8;
  assign var_diff  = $signed({1'b0, sq_sh}) - $signed(DIFF_W'($unsigned(msq) >> 8));
  assign var_c     = var_diff[DIFF_W-1] ? '0 : var_diff[VAR_W-1:0];
  assign mean_o    = rms_q ? '0 : mean_c;
  assign var_o     = rms_q ? sq_sh[VAR_W-1:0] : var_c;
  assign unused_hi = ^{mean_full[PM_W-1:MEAN_W], var_diff[DIFF_W-2:VAR_W]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start && cfg_ok) state_nxt = ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (hs && last_beat) state_nxt = DRAIN;
      end
      DRAIN: state_nxt = EMIT;
      EMIT: if (out_fire && last_out) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef LN_STAT_RMS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   rms_q <= 1'b0;
    else if (state == IDLE && start && cfg_ok) rms_q <= cfg_rms;
  end
`else
  assign rms_q = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_num_q  <= '0;
      ch_slice_q <= '0;
      recip_q    <= '0;
      pix_cnt    <= '0;
      slice_cnt  <= '0;
      s1_valid   <= 1'b0;
      s1_first   <= 1'b0;
      s1_addr    <= '0;
      s1_sum     <= '0;
      s1_sq      <= '0;
      byp_sel    <= 1'b0;
      byp_data   <= '0;
      iss_cnt    <= '0;
      a_valid    <= 1'b0;
      a_pix      <= '0;
      b_valid    <= 1'b0;
      b_pix      <= '0;
      b_pm       <= '0;
      b_ps       <= '0;
      out_valid  <= 1'b0;
      out_pixel  <= '0;
      out_mean   <= '0;
      out_var    <= '0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      done     <= out_fire && last_out;
      cfg_err  <= (state == IDLE) && start && !cfg_ok;
      s1_valid <= hs;

      if (state == IDLE && start && cfg_ok) begin
        pix_num_q  <= cfg_pixel_num;
        ch_slice_q <= cfg_ch_slice;
        recip_q    <= cfg_recip_ch;
        pix_cnt    <= '0;
        slice_cnt  <= '0;
      end

      if (hs) begin
        s1_sum   <= sum_tree[0];
        s1_sq    <= sq_tree[0];
        s1_addr  <= pix_cnt;
        s1_first <= (slice_cnt == '0);
        if (pix_last) begin
          pix_cnt   <= '0;
          slice_cnt <= slice_cnt + CS_W'(1);
        end else begin
          pix_cnt <= pix_cnt + LOG2_PIXEL'(1);
        end
      end

      if (rd_en) begin
        byp_sel  <= wr_en && (s1_addr == rd_addr);
        byp_data <= wr_data;
      end

      if (state != EMIT) begin
        iss_cnt   <= '0;
        a_valid   <= 1'b0;
        b_valid   <= 1'b0;
        out_valid <= 1'b0;
      end else if (adv) begin
        a_valid <= issue_ok;
        a_pix   <= iss_cnt[LOG2_PIXEL-1:0];
        if (issue_ok) iss_cnt <= iss_cnt + PIX_W'(1);
        b_valid <= a_valid;
        b_pix   <= a_pix;
        b_pm    <= PM_W'(old_sum) * PM_W'($signed({1'b0, recip_q}));
        b_ps    <= PS_W'(old_sq) * PS_W'(recip_q);
        out_valid <= b_valid;
        if (b_valid) begin
          out_pixel <= b_pix;
          out_mean  <= mean_o;
          out_var   <= var_o;
        end
      end
    end
  end

endmodule

// File: tb/tb_ln_stat_engine.sv
// Directed testbench for ln_stat_engine (default parameters).
module tb_ln_stat_engine;
  localparam int TOUT = 32;
  localparam int DAT_DW = 8;
  localparam int LOG2_PIXEL = 9;
  localparam int MAX_CH_SLICE = 64;
  localparam int DW = TOUT*DAT_DW;

  logic                          clk = 1'b0;
  logic                          rst = 1'b1;
  logic                          start = 1'b0;
  logic [LOG2_PIXEL:0]           cfg_pixel_num = '0;
  logic [$clog2(MAX_CH_SLICE):0] cfg_ch_slice = '0;
  logic [15:0]                   cfg_recip_ch = '0;
  logic                          cfg_rms = 1'b0;
  logic                          in_valid = 1'b0;
  logic                          in_ready;
  logic [DW-1:0]                 in_data = '0;
  logic                          out_valid;
  logic                          out_ready = 1'b1;
  logic [LOG2_PIXEL-1:0]         out_pixel;
  logic signed [DAT_DW+7:0]      out_mean;
  logic [2*DAT_DW+7:0]           out_var;
  logic                          busy, done, cfg_err;

  ln_stat_engine dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_pixel_num(cfg_pixel_num), .cfg_ch_slice(cfg_ch_slice), .cfg_recip_ch(cfg_recip_ch),
`ifdef LN_STAT_RMS_EN
    .cfg_rms(cfg_rms),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
    .out_mean(out_mean), .out_var(out_var),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  int got_pix[$];
  int got_mean[$];
  int got_var[$];

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_data(input int a, input int b);
    logic [DW-1:0] d;
    d = '0;
    for (int k = 0; k < TOUT; k++)
      d[k*DAT_DW +: DAT_DW] = (k % 2 == 0) ? DAT_DW'(a) : DAT_DW'(b);
    return d;
  endfunction

  // all tasks start and end at posedge+1
  task automatic do_start(input int pix, input int slc, input int recip, input logic rms);
    cfg_pixel_num = pix[LOG2_PIXEL:0];
    cfg_ch_slice  = slc[$clog2(MAX_CH_SLICE):0];
    cfg_recip_ch  = recip[15:0];
    cfg_rms       = rms;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic collect(input int n, input int st, input int sl,
                         output int first_cyc, output int dones);
    int cyc, hp, hm, hv;
    bit held;
    cyc = 0; held = 0; hp = 0; hm = 0; hv = 0;
    first_cyc = -1; dones = 0;
    got_pix.delete(); got_mean.delete(); got_var.delete();
    while (got_pix.size() < n && cyc < 4000) begin
      out_ready = !(cyc >= st && cyc < st + sl);
      if (done) dones++;
      if (out_valid && first_cyc < 0) first_cyc = cyc;
      if (out_valid && !out_ready) begin
        if (held) begin
          check("stall_pixel", int'(out_pixel), hp);
          check("stall_mean", int'(out_mean), hm);
          check("stall_var", int'(out_var), hv);
        end
        held = 1; hp = int'(out_pixel); hm = int'(out_mean); hv = int'(out_var);
      end else begin
        held = 0;
      end
      if (out_valid && out_ready) begin
        got_pix.push_back(int'(out_pixel));
        got_mean.push_back(int'(out_mean));
        got_var.push_back(int'(out_var));
      end
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b1;
    if (got_pix.size() < n) check("collect_timeout", got_pix.size(), n);
    for (int i = 0; i < 3; i++) begin
      if (done) dones++;
      @(posedge clk); #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, int'(in_ready), 0);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_out_pixel"}, int'(out_pixel), 0);
    check({tag, "_out_mean"}, int'(out_mean), 0);
    check({tag, "_out_var"}, int'(out_var), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_cfg_err"}, int'(cfg_err), 0);
  endtask

  initial begin
    int fc, dn;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // two pixels, one slice, 32 channels
    do_start(2, 1, 2048, 1'b0);
    check("t1_busy", int'(busy), 1);
    send_beat(mk_data(4, 4));
    send_beat(mk_data(2, -2));
    in_valid = 1'b0;
    collect(2, 1000, 0, fc, dn);
    check("t1_first_valid_cyc", fc, 4);
    check("t1_p0_pix", got_pix[0], 0);
    check("t1_p0_mean", got_mean[0], 1024);
    check("t1_p0_var", got_var[0], 0);
    check("t1_p1_pix", got_pix[1], 1);
    check("t1_p1_mean", got_mean[1], 0);
    check("t1_p1_var", got_var[1], 1024);
    check("t1_done_pulses", dn, 1);
    check("t1_busy_end", int'(busy), 0);

    // one pixel, three slices back to back: accumulation through the bypass
    do_start(1, 3, 683, 1'b0);
    for (int s = 0; s < 3; s++) send_beat(mk_data(1, 1));
    in_valid = 1'b0;
    collect(1, 1000, 0, fc, dn);
    check("t2_mean", got_mean[0], 256);
    check("t2_var", got_var[0], 0);
    check("t2_done_pulses", dn, 1);

    // four pixels, two slices (x then 3x), downstream stall of 5 cycles
    do_start(4, 2, 1024, 1'b0);
    for (int p = 0; p < 4; p++) send_beat(mk_data(p + 1, p + 1));
    for (int p = 0; p < 4; p++) send_beat(mk_data(3*(p + 1), 3*(p + 1)));
    in_valid = 1'b0;
    collect(4, 5, 5, fc, dn);
    check("t3_count", got_pix.size(), 4);
    for (int p = 0; p < 4; p++) begin
      check("t3_pix", got_pix[p], p);
      check("t3_mean", got_mean[p], 512*(p + 1));
      check("t3_var", got_var[p], 256*(p + 1)*(p + 1));
    end
    check("t3_done_pulses", dn, 1);

    // illegal configurations
    do_start(0, 1, 2048, 1'b0);
    check("t4_err0", int'(cfg_err), 1);
    check("t4_busy0", int'(busy), 0);
    @(posedge clk); #1;
    check("t4_err_pulse_end", int'(cfg_err), 0);
    do_start(1, MAX_CH_SLICE + 1, 2048, 1'b0);
    check("t4_err1", int'(cfg_err), 1);
    check("t4_busy1", int'(busy), 0);
    @(posedge clk); #1;
    check("t4_busy_after", int'(busy), 0);

    // full depth, full slices, most negative input
    do_start(1 << LOG2_PIXEL, MAX_CH_SLICE, 32, 1'b0);
    for (int i = 0; i < (MAX_CH_SLICE << LOG2_PIXEL); i++) send_beat(mk_data(-128, -128));
    in_valid = 1'b0;
    collect(1 << LOG2_PIXEL, 1000000, 0, fc, dn);
    for (int p = 0; p < got_pix.size(); p++) begin
      check("t5_pix", got_pix[p], p);
      check("t5_mean", got_mean[p], -32768);
      check("t5_var", got_var[p], 0);
    end
    check("t5_done_pulses", dn, 1);

    // abort mid-accumulation
    do_start(4, 2, 1024, 1'b0);
    for (int i = 0; i < 3; i++) send_beat(mk_data(7, 7));
    rst = 1'b1;
    #2;
    in_valid = 1'b0;
    check_reset_outputs("abort");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // run after abort: lanes 5/-3 -> mean 1.0, var 16.0
    do_start(1, 1, 2048, 1'b0);
    send_beat(mk_data(5, -3));
    in_valid = 1'b0;
    collect(1, 1000, 0, fc, dn);
    check("t6_mean", got_mean[0], 256);
    check("t6_var", got_var[0], 4096);
    check("t6_done_pulses", dn, 1);

`ifdef LN_STAT_RMS_EN
    do_start(1, 1, 2048, 1'b1);
    send_beat(mk_data(3, 3));
    in_valid = 1'b0;
    collect(1, 1000, 0, fc, dn);
    check("rms_mean", got_mean[0], 0);
    check("rms_var", got_var[0], 2304);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ln_stat_engine.md
Name: ln_stat_engine

Overview:
- Streaming LayerNorm statistics engine: computes per-pixel mean and variance across all channels, for the LN path of Vit_wrapper.
- Input is Tout-wide channel-slice vectors in surface-major order, the DDR feature layout: slice 0 for all pixels, then slice 1 for all pixels, and so on.
- Per-pixel partial sums are kept in an internal RAM whose depth is a parameter, removing the fixed 256-pixel limit.
- After the last slice, the engine streams out mean and variance per pixel to the normalise stage.

Parameters:
- TOUT, 32, lanes per input vector.
- DAT_DW, 8, signed element width.
- LOG2_PIXEL, 9, log2 of the pixel RAM depth; max pixels = 2^LOG2_PIXEL.
- MAX_CH_SLICE, 64, max channel slices per pixel.
- SUM_DW, DAT_DW+$clog2(TOUT*MAX_CH_SLICE), width of the signed sum accumulator.
- SQ_DW, 2*DAT_DW+$clog2(TOUT*MAX_CH_SLICE), width of the unsigned sum-of-squares accumulator.

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-high reset.
- start, in, 1, one-cycle pulse; samples the cfg_* inputs.
- cfg_pixel_num, in, LOG2_PIXEL+1, pixel count, legal range 1..2^LOG2_PIXEL.
- cfg_ch_slice, in, $clog2(MAX_CH_SLICE)+1, slice count, legal range 1..MAX_CH_SLICE.
- cfg_recip_ch, in, 16, unsigned Q0.16 value round(65536/channel_count).
- in_valid, in, 1, input vector valid.
- in_ready, out, 1, engine accepts an input vector.
- in_data, in, TOUT*DAT_DW, lane k is bits [k*DAT_DW +: DAT_DW], signed.
- out_valid, out, 1, statistics word valid.
- out_ready, in, 1, downstream accepts the statistics word.
- out_pixel, out, LOG2_PIXEL, pixel index of the current output.
- out_mean, out, DAT_DW+8, signed mean, 8 fractional bits.
- out_var, out, 2*DAT_DW+8, unsigned variance, 8 fractional bits.
- busy, out, 1, high in every state except IDLE.
- done, out, 1, one-cycle pulse after the last output handshake.
- cfg_err, out, 1, one-cycle pulse when start carries an illegal configuration.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_pixel=0, out_mean=0, out_var=0, busy=0, done=0, cfg_err=0; FSM goes to IDLE; pixel and slice counters cleared. RAM contents are not cleared.
- Reset mid-operation aborts the run. No done pulse is produced. The next run is unaffected because slice 0 overwrites RAM rather than accumulating into it.
- States: IDLE -> ACCUM -> DRAIN -> EMIT -> IDLE.
- IDLE:
  - start with a legal cfg: latch cfg, go to ACCUM.
  - start with an illegal cfg (a count of 0 or above its maximum): pulse cfg_err next cycle, stay in IDLE.
  - start while busy is ignored.
- ACCUM:
  - in_ready=1. A handshake is in_valid&in_ready.
  - Per handshake: lane sum (signed, tree adder) and lane sum of squares are computed; RAM is read at pix_cnt.
  - Next cycle: write {sum,sq} = slice_cnt==0 ? new : old+new.
  - Counters: pix_cnt wraps at cfg_pixel_num-1 and increments slice_cnt. After the handshake with the last pixel of the last slice, go to DRAIN.
  - Back-to-back accesses to the same address (cfg_pixel_num==1) use a write-to-read bypass, so no stall and no lost accumulation.
  - Zero-padded tail channels contribute 0 to both sums.
- DRAIN: one cycle so the final write lands; in_ready=0.
- EMIT: 3-stage pipeline: RAM read, multiply, subtract/clamp.
  - mean = (sum*recip) >>> 8.
  - var = ((sq*recip) >> 8) - ((mean*mean) >> 8). A negative result clamps to 0.
  - Products are full width; out_mean and out_var take the low bits, and the result is guaranteed in range by the operand widths.
  - The pipeline advances when !out_valid | out_ready. Once the pipeline is full, throughput is 1 pixel/clk. The first out_valid comes 3 cycles after EMIT entry.
  - Pixels are emitted in order 0..cfg_pixel_num-1. The last handshake gives done=1 next cycle and a return to IDLE.
- out_* are held stable while out_valid&!out_ready.

Optional Feature:
- Macro: LN_STAT_RMS_EN.
- When defined:
  - Adds input port cfg_rms (1 bit), latched on start.
  - When cfg_rms=1: out_mean is forced to 0 and out_var = (sq*recip)>>8 (RMSNorm mean-square); the mean multiplier result is unused.
- When undefined: no port is added; behaviour is always LayerNorm.

Test Plan:
- cfg_pixel_num=2, cfg_ch_slice=1, cfg_recip_ch=2048 (CH=32); pixel0 all lanes 4, pixel1 lanes alternating 2/-2 -> pixel0 mean=1024 (4.0), var=0; pixel1 mean=0, var=1024 (4.0); done pulses once.
- cfg_pixel_num=1, cfg_ch_slice=3, recip=683, every lane 1 on every beat, in_valid held high -> exercises the bypass; sum=96, out_mean=256 (96*683=65568, >>>8 = 256), out_var=0.
- out_ready held low for 5 cycles during EMIT with 4 pixels -> out_* stable throughout, no pixel dropped or duplicated, out_pixel sequence 0,1,2,3.
- start with cfg_pixel_num=0, then with cfg_ch_slice=MAX_CH_SLICE+1 -> cfg_err pulses twice, busy stays 0.
- Full-depth run (2^LOG2_PIXEL pixels, MAX_CH_SLICE slices, all lanes -128) -> out_mean=-32768 (−128.0), out_var=0, no overflow; then assert rst mid-ACCUM -> all outputs return to their reset values; a following 1-pixel run is correct.
- LN_STAT_RMS_EN defined, cfg_rms=1, 32 lanes equal to 3, recip=2048 -> out_mean=0, out_var=2304 (9.0).
